fifo_wr_gen: RTL and testbench

- Programmable write-side traffic generator on the wclk domain; drives the winc/wdata inputs of the downstream dual-clock FIFO and honours its wfull.
- Emits a configured number of bursts of configured length, separated by idle gaps, with incrementing or LFSR data.
- Counts accepted writes and full-stall cycles for scoreboard and throughput checks in FIFO benches.

---
 rtl/fifo_tb_pkg.sv | 15 +
 rtl/fifo_data_pat.sv | 56 +++++
 rtl/fifo_wr_gen.sv | 149 ++++++++++++++
 tb/tb_fifo_wr_gen.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_tb_pkg.sv
// Shared types and defaults for the FIFO write-side traffic generator.
package fifo_tb_pkg;

  localparam int unsigned DSizeDefault    = 8;
  localparam logic [7:0]  LfsrPolyDefault = 8'hB8;
  localparam logic [7:0]  LfsrSeedDefault = 8'h01;

  typedef enum logic [1:0] {
    StIdle,
    StBurst,
    StGap,
    StDone
  } wr_state_e;

endpackage

// File: rtl/fifo_data_pat.sv
// Write-data pattern source: incrementing counter or Galois LFSR, selected at load time.
module fifo_data_pat
  import fifo_tb_pkg::*;
#(
  parameter int unsigned      DSIZE     = DSizeDefault,
  parameter logic [DSIZE-1:0] LFSR_POLY = LfsrPolyDefault,
  parameter logic [DSIZE-1:0] LFSR_SEED = LfsrSeedDefault
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             load,
  input  logic             advance,
  input  logic             mode,
  output logic [DSIZE-1:0] wdata
);

  localparam logic [DSIZE-1:0] IncOne = DSIZE'(1);

  logic             mode_q, mode_d;
  logic [DSIZE-1:0] inc_q, inc_d;
  logic [DSIZE-1:0] lfsr_q, lfsr_d;

  // Next pattern value: load restarts both sources, advance steps only the selected one.
  always_comb begin
    mode_d = mode_q;
    inc_d  = inc_q;
    lfsr_d = lfsr_q;
    if (load) begin
      mode_d = mode;
      inc_d  = '0;
      lfsr_d = LFSR_SEED;
    end else if (advance) begin
      if (mode_q) begin
        lfsr_d = {1'b0, lfsr_q[DSIZE-1:1]} ^ (lfsr_q[0] ? LFSR_POLY : '0);
      end else begin
        inc_d = inc_q + IncOne;
      end
    end
  end

  // Pattern registers with synchronous reset.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      mode_q <= 1'b0;
      inc_q  <= '0;
      lfsr_q <= LFSR_SEED;
    end else begin
      mode_q <= mode_d;
      inc_q  <= inc_d;
      lfsr_q <= lfsr_d;
    end
  end

  assign wdata = mode_q ? lfsr_q : inc_q;

endmodule

// File: rtl/fifo_wr_gen.sv
// Burst traffic generator driving the write side of a dual-clock FIFO, with write/stall stats.
module fifo_wr_gen
  import fifo_tb_pkg::*;
#(
  parameter int unsigned      DSIZE     = DSizeDefault,
  parameter int unsigned      CNT_W     = 16,
  parameter logic [DSIZE-1:0] LFSR_POLY = LfsrPolyDefault,
  parameter logic [DSIZE-1:0] LFSR_SEED = LfsrSeedDefault
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [CNT_W-1:0] gap_len,
  input  logic [CNT_W-1:0] num_bursts,
  input  logic             wfull,
  output logic             winc,
  output logic [DSIZE-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  wr_state_e        state_q, state_d;
  logic [CNT_W-1:0] burst_len_q, burst_len_d;
  logic [CNT_W-1:0] gap_len_q, gap_len_d;
  logic [CNT_W-1:0] num_bursts_q, num_bursts_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             load;

  // A write is accepted whenever this is high at a clock edge.
  assign winc = (state_q == StBurst) && !wfull;

  // Next-state, counters and pattern control.
  always_comb begin
    state_d       = state_q;
    burst_len_d   = burst_len_q;
    gap_len_d     = gap_len_q;
    num_bursts_d  = num_bursts_q;
    beat_cnt_d    = beat_cnt_q;
    burst_cnt_d   = burst_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    wr_count_d    = wr_count_q;
    stall_count_d = stall_count_q;
    load          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          burst_len_d   = burst_len;
          gap_len_d     = gap_len;
          num_bursts_d  = num_bursts;
          beat_cnt_d    = '0;
          burst_cnt_d   = '0;
          gap_cnt_d     = '0;
          wr_count_d    = '0;
          stall_count_d = '0;
          load          = 1'b1;
          state_d       = (num_bursts == '0 || burst_len == '0) ? StDone : StBurst;
        end
      end
      StBurst: begin
        if (wfull) begin
          if (stall_count_q != '1) stall_count_d = stall_count_q + CntOne;
        end else begin
          wr_count_d = wr_count_q + CntOne;
          if (beat_cnt_q + CntOne == burst_len_q) begin
            beat_cnt_d = '0;
            if (burst_cnt_q + CntOne == num_bursts_q) begin
              state_d = StDone;
            end else begin
              burst_cnt_d = burst_cnt_q + CntOne;
              gap_cnt_d   = '0;
              // Zero gap chains straight into the next burst.
              state_d     = (gap_len_q == '0) ? StBurst : StGap;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + CntOne;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q + CntOne == gap_len_q) begin
          state_d = StBurst;
        end else begin
          gap_cnt_d = gap_cnt_q + CntOne;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q       <= StIdle;
      burst_len_q   <= '0;
      gap_len_q     <= '0;
      num_bursts_q  <= '0;
      beat_cnt_q    <= '0;
      burst_cnt_q   <= '0;
      gap_cnt_q     <= '0;
      wr_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      burst_len_q   <= burst_len_d;
      gap_len_q     <= gap_len_d;
      num_bursts_q  <= num_bursts_d;
      beat_cnt_q    <= beat_cnt_d;
      burst_cnt_q   <= burst_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      wr_count_q    <= wr_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  fifo_data_pat #(
    .DSIZE    (DSIZE),
    .LFSR_POLY(LFSR_POLY),
    .LFSR_SEED(LFSR_SEED)
  ) u_data_pat (
    .wclk   (wclk),
    .wrst   (wrst),
    .load   (load),
    .advance(winc),
    .mode   (mode),
    .wdata  (wdata)
  );

  assign busy        = (state_q == StBurst) || (state_q == StGap);
  assign done        = (state_q == StDone);
  assign wr_count    = wr_count_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fifo_wr_gen.sv
// Self-checking bench for fifo_wr_gen against a burst/gap reference model.
module tb_fifo_wr_gen;

  logic        wclk = 1'b0;
  logic        wrst, start, mode, wfull;
  logic [15:0] burst_len, gap_len, num_bursts;
  logic        winc, busy, done;
  logic [7:0]  wdata;
  logic [15:0] wr_count, stall_count;

  always #5 wclk = ~wclk;

  fifo_wr_gen #(
    .DSIZE    (8),
    .CNT_W    (16),
    .LFSR_POLY(8'hB8),
    .LFSR_SEED(8'h01)
  ) dut (
    .wclk       (wclk),
    .wrst       (wrst),
    .start      (start),
    .mode       (mode),
    .burst_len  (burst_len),
    .gap_len    (gap_len),
    .num_bursts (num_bursts),
    .wfull      (wfull),
    .winc       (winc),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .wr_count   (wr_count),
    .stall_count(stall_count)
  );

  int checks = 0;
  int passed = 0;

  // Observed run record; index k holds cycle k+1 after the start edge.
  bit         obs_winc[$], obs_busy[$], obs_full[$];
  logic [7:0] obs_wdata[$], obs_acc[$];
  logic [7:0] fifo_q[$], fifo_out[$];
  int         obs_done_at, obs_done_cnt;
  bit         timed_out;
  logic [15:0] fin_wr, fin_stall;

  // Model expectations for the same run.
  bit         exp_winc[$], exp_busy[$];
  logic [7:0] exp_data[$];
  int         exp_done_at, exp_stall;

  function automatic logic [7:0] step(bit m, logic [7:0] d);
    if (m) return {1'b0, d[7:1]} ^ (d[0] ? 8'hB8 : 8'h00);
    return d + 8'd1;
  endfunction

  // Walks the burst/gap schedule against the recorded wfull trace.
  task automatic model(input bit m, input int bl, input int gl, input int nb);
    int total, phase, rem, gap_left, bursts_left;
    logic [7:0] d;
    total = (bl == 0 || nb == 0) ? 0 : bl * nb;
    exp_data.delete();
    d = m ? 8'h01 : 8'h00;
    for (int i = 0; i < total; i++) begin
      exp_data.push_back(d);
      d = step(m, d);
    end
    exp_winc.delete(); exp_busy.delete();
    exp_done_at = -1; exp_stall = 0;
    phase = (total == 0) ? 2 : 0;  // 0 burst, 1 gap, 2 done cycle, 3 idle
    rem = bl; gap_left = 0; bursts_left = nb;
    for (int k = 0; k < obs_full.size(); k++) begin
      case (phase)
        0: begin
          exp_busy.push_back(1'b1);
          if (obs_full[k]) begin
            exp_winc.push_back(1'b0);
            if (exp_stall < 65535) exp_stall++;
          end else begin
            exp_winc.push_back(1'b1);
            rem--;
            if (rem == 0) begin
              bursts_left--;
              if (bursts_left == 0) phase = 2;
              else if (gl == 0) rem = bl;
              else begin phase = 1; gap_left = gl; end
            end
          end
        end
        1: begin
          exp_busy.push_back(1'b1); exp_winc.push_back(1'b0);
          gap_left--;
          if (gap_left == 0) begin phase = 0; rem = bl; end
        end
        2: begin
          exp_busy.push_back(1'b0); exp_winc.push_back(1'b0);
          exp_done_at = k + 1; phase = 3;
        end
        default: begin
          exp_busy.push_back(1'b0); exp_winc.push_back(1'b0);
        end
      endcase
    end
  endtask

  // kind: 0 no backpressure, 1 random wfull, 2 five-cycle stall after 3rd write, 3 depth-4 FIFO
  task automatic run_gen(input bit m, input int bl, input int gl, input int nb, input int kind,
                         input int restart_at, input int max_cycles);
    int stall_left, writes;
    bit rd_phase, broke;
    obs_winc.delete(); obs_busy.delete(); obs_full.delete(); obs_wdata.delete();
    obs_acc.delete(); fifo_q.delete(); fifo_out.delete();
    obs_done_at = -1; obs_done_cnt = 0; stall_left = 0; writes = 0; rd_phase = 0; broke = 0;
    @(posedge wclk); #1;
    mode = m; burst_len = 16'(bl); gap_len = 16'(gl); num_bursts = 16'(nb);
    start = 1'b1; wfull = 1'b0;
    @(posedge wclk); #1;
    start = 1'b0;
    // Scramble config after the start edge; the generator must ignore it.
    mode = 1'($urandom); burst_len = 16'($urandom_range(0, 9));
    gap_len = 16'($urandom_range(0, 9)); num_bursts = 16'($urandom_range(0, 9));
    for (int k = 1; k <= max_cycles; k++) begin
      case (kind)
        1:       wfull = ($urandom_range(0, 3) == 0);
        2:       wfull = (stall_left > 0);
        3:       wfull = (fifo_q.size() >= 4);
        default: wfull = 1'b0;
      endcase
      start = (k == restart_at);
      @(negedge wclk);
      obs_full.push_back(wfull); obs_winc.push_back(winc);
      obs_busy.push_back(busy);  obs_wdata.push_back(wdata);
      if (done) begin
        obs_done_cnt++;
        if (obs_done_at < 0) obs_done_at = k;
      end
      if (winc) begin
        obs_acc.push_back(wdata); writes++;
        if (kind == 3) fifo_q.push_back(wdata);
      end
      if (kind == 2) begin
        if (stall_left > 0) stall_left--;
        else if (winc && writes == 3) stall_left = 5;
      end
      if (kind == 3) begin
        rd_phase = !rd_phase;
        if (rd_phase && fifo_q.size() > 0) fifo_out.push_back(fifo_q.pop_front());
      end
      @(posedge wclk); #1;
      if (obs_done_at >= 0 && k >= obs_done_at + 2) begin broke = 1; break; end
    end
    timed_out = !broke;
    start = 1'b0; wfull = 1'b0;
    while (fifo_q.size() > 0) fifo_out.push_back(fifo_q.pop_front());
    fin_wr = wr_count; fin_stall = stall_count;
    model(m, bl, gl, nb);
  endtask

  task automatic test_reset();
    wrst = 1'b1; start = 1'b0; mode = 1'b0; wfull = 1'b0;
    burst_len = '0; gap_len = '0; num_bursts = '0;
    repeat (3) @(posedge wclk);
    #1 wrst = 1'b0;
    @(negedge wclk);
    checks++; if (winc !== 1'b0) $display("FAIL reset_winc: got %b want 0", winc); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    checks++; if (wdata !== 8'h00) $display("FAIL reset_wdata: got %h want 00", wdata); else passed++;
    checks++;
    if (wr_count !== 16'd0) $display("FAIL reset_wr_count: got %0d want 0", wr_count);
    else passed++;
    checks++;
    if (stall_count !== 16'd0) $display("FAIL reset_stall_count: got %0d want 0", stall_count);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    run_gen(1'b0, 4, 0, 2, 0, 0, 100);
    checks++; if (timed_out) $display("FAIL b2b_timeout: no done seen, want done"); else passed++;
    for (int i = 0; i < 8; i++) if (obs_winc[i] !== 1'b1 || obs_wdata[i] !== 8'(i)) bad++;
    checks++;
    if (bad != 0) $display("FAIL b2b_first8: %0d of cycles 1..8 wrong, want 0", bad);
    else passed++;
    checks++;
    if (obs_acc.size() != 8) $display("FAIL b2b_nwrites: got %0d want 8", obs_acc.size());
    else passed++;
    checks++; if (obs_done_at != 9) $display("FAIL b2b_done_at: got %0d want 9", obs_done_at);
    else passed++;
    checks++; if (fin_wr !== 16'd8) $display("FAIL b2b_wr_count: got %0d want 8", fin_wr);
    else passed++;
    checks++; if (fin_stall !== 16'd0) $display("FAIL b2b_stall: got %0d want 0", fin_stall);
    else passed++;
  endtask

  task automatic test_gap();
    int bad_w = 0, bad_b = 0, bad_d = 0;
    run_gen(1'b0, 4, 3, 2, 0, 0, 100);
    for (int i = 0; i < obs_winc.size(); i++) begin
      if (obs_winc[i] !== exp_winc[i]) bad_w++;
      if (obs_busy[i] !== exp_busy[i]) bad_b++;
    end
    checks++; if (bad_w != 0) $display("FAIL gap_winc_trace: %0d cycles differ, want 0", bad_w);
    else passed++;
    checks++; if (bad_b != 0) $display("FAIL gap_busy_trace: %0d cycles differ, want 0", bad_b);
    else passed++;
    for (int i = 4; i < 7; i++) if (obs_winc[i] !== 1'b0 || obs_busy[i] !== 1'b1) bad_d++;
    for (int i = 0; i < 8; i++) if (i >= obs_acc.size() || obs_acc[i] !== 8'(i)) bad_d++;
    checks++; if (bad_d != 0) $display("FAIL gap_window_data: %0d errors, want 0", bad_d);
    else passed++;
    checks++; if (obs_done_at != 12) $display("FAIL gap_done_at: got %0d want 12", obs_done_at);
    else passed++;
  endtask

  task automatic test_lfsr();
    logic [7:0] want [5];
    int bad = 0;
    want = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17};
    run_gen(1'b1, 5, 0, 1, 0, 0, 50);
    for (int i = 0; i < 5; i++) if (i >= obs_acc.size() || obs_acc[i] !== want[i]) bad++;
    checks++; if (bad != 0 || obs_acc.size() != 5)
      $display("FAIL lfsr_data: %0d wrong of %0d writes, want 0 of 5", bad, obs_acc.size());
    else passed++;
    checks++; if (fin_wr !== 16'd5) $display("FAIL lfsr_wr_count: got %0d want 5", fin_wr);
    else passed++;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    run_gen(1'b0, 8, 0, 1, 2, 0, 100);
    for (int i = 3; i < 8; i++) if (obs_winc[i] !== 1'b0 || obs_wdata[i] !== 8'h03) bad++;
    checks++; if (bad != 0) $display("FAIL bp_hold: %0d stall cycles wrong, want 0", bad);
    else passed++;
    bad = 0;
    for (int i = 0; i < 8; i++) if (i >= obs_acc.size() || obs_acc[i] !== 8'(i)) bad++;
    checks++; if (bad != 0 || obs_acc.size() != 8)
      $display("FAIL bp_data: %0d wrong of %0d writes, want 0 of 8", bad, obs_acc.size());
    else passed++;
    checks++; if (fin_stall !== 16'd5) $display("FAIL bp_stall: got %0d want 5", fin_stall);
    else passed++;
    checks++; if (fin_wr !== 16'd8) $display("FAIL bp_wr_count: got %0d want 8", fin_wr);
    else passed++;
    checks++; if (obs_done_at != 14) $display("FAIL bp_done_at: got %0d want 14", obs_done_at);
    else passed++;
  endtask

  task automatic test_degenerate();
    run_gen(1'b0, 4, 2, 0, 0, 0, 20);
    checks++; if (obs_done_at != 1 || obs_acc.size() != 0)
      $display("FAIL nb0: done_at %0d writes %0d, want 1 and 0", obs_done_at, obs_acc.size());
    else passed++;
    run_gen(1'b1, 0, 0, 3, 0, 0, 20);
    checks++; if (obs_done_at != 1 || obs_acc.size() != 0)
      $display("FAIL bl0: done_at %0d writes %0d, want 1 and 0", obs_done_at, obs_acc.size());
    else passed++;
  endtask

  task automatic test_start_while_busy();
    int bad = 0;
    run_gen(1'b0, 6, 1, 2, 0, 2, 100);
    for (int i = 0; i < obs_winc.size(); i++) if (obs_winc[i] !== exp_winc[i]) bad++;
    for (int i = 0; i < 12; i++) if (i >= obs_acc.size() || obs_acc[i] !== 8'(i)) bad++;
    checks++; if (bad != 0 || obs_done_cnt != 1)
      $display("FAIL restart_ignored: %0d errors, %0d done pulses, want 0 and 1", bad, obs_done_cnt);
    else passed++;
    checks++; if (fin_wr !== 16'd12) $display("FAIL restart_wr_count: got %0d want 12", fin_wr);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    @(posedge wclk); #1;
    mode = 1'b0; burst_len = 16'd6; gap_len = 16'd0; num_bursts = 16'd1;
    start = 1'b1; wfull = 1'b0;
    @(posedge wclk); #1 start = 1'b0;
    @(negedge wclk);
    checks++; if (winc !== 1'b1) $display("FAIL rmid_pre_winc: got %b want 1", winc); else passed++;
    @(posedge wclk); #1 wrst = 1'b1;
    @(posedge wclk); #1;
    checks++; if (winc !== 1'b0 || busy !== 1'b0 || wr_count !== 16'd0 || wdata !== 8'h00)
      $display("FAIL rmid_after: winc %b busy %b wr_count %0d wdata %h, want 0 0 0 00",
               winc, busy, wr_count, wdata);
    else passed++;
    wrst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge wclk);
      if (done !== 1'b0 || winc !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL rmid_quiet: %0d cycles with done/winc, want 0", bad);
    else passed++;
  endtask

  task automatic test_fifo_integration();
    int bad = 0;
    run_gen(1'b0, 16, 0, 1, 3, 0, 400);
    checks++; if (fin_stall == 16'd0) $display("FAIL fifo_stalls: got 0 want >0"); else passed++;
    checks++; if (int'(fin_stall) != exp_stall)
      $display("FAIL fifo_stall_count: got %0d want %0d", fin_stall, exp_stall);
    else passed++;
    for (int i = 0; i < 16; i++) if (i >= fifo_out.size() || fifo_out[i] !== 8'(i)) bad++;
    checks++; if (bad != 0 || fifo_out.size() != 16)
      $display("FAIL fifo_order: %0d wrong of %0d read, want 0 of 16", bad, fifo_out.size());
    else passed++;
    checks++; if (fin_wr !== 16'd16) $display("FAIL fifo_wr_count: got %0d want 16", fin_wr);
    else passed++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      bit m;
      int bl, gl, nb, bad;
      m = 1'($urandom); bl = $urandom_range(0, 6); gl = $urandom_range(0, 3);
      nb = $urandom_range(0, 3);
      run_gen(m, bl, gl, nb, 1, 0, 300);
      bad = 0;
      for (int i = 0; i < obs_winc.size(); i++)
        if (obs_winc[i] !== exp_winc[i] || obs_busy[i] !== exp_busy[i]) bad++;
      checks++; if (bad != 0 || timed_out)
        $display("FAIL rand%0d_trace: %0d cycles differ, timeout %b, want 0 0", it, bad, timed_out);
      else passed++;
      bad = 0;
      for (int i = 0; i < exp_data.size(); i++)
        if (i >= obs_acc.size() || obs_acc[i] !== exp_data[i]) bad++;
      checks++; if (bad != 0 || obs_acc.size() != exp_data.size())
        $display("FAIL rand%0d_data: %0d wrong, %0d writes, want 0 and %0d",
                 it, bad, obs_acc.size(), exp_data.size());
      else passed++;
      checks++; if (obs_done_at != exp_done_at || obs_done_cnt != 1)
        $display("FAIL rand%0d_done: at %0d count %0d, want at %0d count 1",
                 it, obs_done_at, obs_done_cnt, exp_done_at);
      else passed++;
      checks++; if (int'(fin_wr) != exp_data.size() || int'(fin_stall) != exp_stall)
        $display("FAIL rand%0d_counts: wr %0d stall %0d, want %0d %0d",
                 it, fin_wr, fin_stall, exp_data.size(), exp_stall);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gap();
    test_lfsr();
    test_backpressure();
    test_degenerate();
    test_start_while_busy();
    test_reset_mid();
    test_fifo_integration();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
